// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npu_pkg
//  Description : Shared NPU constants and the activation write arbiter
//                state encoding.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package npu_pkg;

  localparam int NPU_ACT_DATA_WIDTH = 16;
  localparam int NPU_NUM_LANES      = 32;
  localparam int NPU_ACT_MEM_DEPTH  = 4096;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_STALL  = 2'd2
  } arb_state_e;

endpackage : npu_pkg
`default_nettype wire

// File: rtl/npu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : npu_rr_arbiter
//  Description : Stateless round-robin pick. Finds the first set request at or
//                after ptr_i, wrapping from N-1 back to 0.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module npu_rr_arbiter #(
  parameter int N     = 32,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             valid_o
);

  // Rotating a doubled request vector right by ptr puts lane ptr at bit 0,
  // so the lowest set bit is the distance from ptr to the winner.
  logic [N-1:0]   w_rot;
  logic [IDX_W:0] w_off;
  logic [IDX_W:0] w_sum;

  assign w_rot = N'({req_i, req_i} >> ptr_i);

  // Lowest-set-bit search on the rotated vector, then map back to a lane index.
  always_comb begin
    valid_o = 1'b0;
    w_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        valid_o = 1'b1;
        w_off   = (IDX_W + 1)'(k);
      end
    end
    w_sum = {1'b0, ptr_i} + w_off;
    if (w_sum >= (IDX_W + 1)'(N)) begin
      w_sum = w_sum - (IDX_W + 1)'(N);
    end
    grant_idx_o = w_sum[IDX_W-1:0];
    grant_o     = valid_o ? (N'(1) << grant_idx_o) : '0;
  end

endmodule : npu_rr_arbiter
`default_nettype wire

// File: rtl/npu_act_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : npu_act_wr_arbiter
//  Description : Round-robin arbitration of MAC-lane activation writes onto
//                the single activation memory write port, with layer base
//                offset, stall, test-mode suppression, write counter and
//                sticky out-of-range flag.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module npu_act_wr_arbiter
  import npu_pkg::*;
#(
  parameter int NUM_LANES   = NPU_NUM_LANES,
  parameter int LANE_ADDR_W = 12,
  parameter int MEM_ADDR_W  = 12,
  parameter int MEM_DEPTH   = NPU_ACT_MEM_DEPTH,
  parameter int DATA_W      = NPU_ACT_DATA_WIDTH,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LANES-1:0]           lane_wr_req,
  input  logic [NUM_LANES*LANE_ADDR_W-1:0] lane_wr_addr,
  input  logic [NUM_LANES*DATA_W-1:0]    lane_wr_data,
  output logic [NUM_LANES-1:0]           lane_wr_ack_p,
  input  logic [MEM_ADDR_W-1:0]          base_addr_i,
  input  logic                           stall_i,
  input  logic                           test_mode_i,
  input  logic                           cnt_clr_i,
  output logic                           mem_wr_en_o,
  output logic [MEM_ADDR_W-1:0]          mem_wr_addr_o,
  output logic [DATA_W-1:0]              mem_wr_data_o,
  output logic                           busy_o,
  output logic [CNT_W-1:0]               wr_count_o,
  output logic                           addr_oob_o
);

  localparam int IDX_W = $clog2(NUM_LANES);
  // One extra bit beyond the wider operand keeps the unwrapped sum exact.
  localparam int SUM_W = ((MEM_ADDR_W > LANE_ADDR_W) ? MEM_ADDR_W : LANE_ADDR_W) + 1;

  logic [NUM_LANES-1:0]   ack_q;
  logic                   wr_en_q;
  logic [MEM_ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]      data_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   oob_q;
  arb_state_e             state_q;

  logic [NUM_LANES-1:0]   w_elig;
  logic [NUM_LANES-1:0]   w_gnt_oh;
  logic [IDX_W-1:0]       w_gnt_idx;
  logic                   w_gnt_vld;
  logic                   w_grant;
  logic [LANE_ADDR_W-1:0] w_lane_addr;
  logic [DATA_W-1:0]      w_lane_data;
  logic [SUM_W-1:0]       w_sum;
  logic                   w_oob;
  logic [IDX_W-1:0]       ptr_d;

  // A lane still holds req during its ack cycle; mask it so it is not re-granted.
  assign w_elig = lane_wr_req & ~ack_q;

  npu_rr_arbiter #(
    .N     (NUM_LANES),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i       (w_elig),
    .ptr_i       (ptr_q),
    .grant_o     (w_gnt_oh),
    .grant_idx_o (w_gnt_idx),
    .valid_o     (w_gnt_vld)
  );

  assign w_grant     = w_gnt_vld & ~stall_i;
  assign w_lane_addr = lane_wr_addr[int'(w_gnt_idx) * LANE_ADDR_W +: LANE_ADDR_W];
  assign w_lane_data = lane_wr_data[int'(w_gnt_idx) * DATA_W +: DATA_W];
  assign w_sum       = SUM_W'(base_addr_i) + SUM_W'(w_lane_addr);
  assign w_oob       = (w_sum >= SUM_W'(MEM_DEPTH));
  assign ptr_d       = (w_gnt_idx == IDX_W'(NUM_LANES - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Write-port registers and round-robin pointer; addr/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      ack_q   <= w_grant ? w_gnt_oh : '0;
      wr_en_q <= w_grant & ~test_mode_i;
      if (w_grant) begin
        addr_q <= w_sum[MEM_ADDR_W-1:0];
        data_q <= w_lane_data;
        ptr_q  <= ptr_d;
      end
    end
  end

  // Saturating grant counter; a clear beats a same-cycle grant.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      cnt_q <= '0;
    end else if (w_grant && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sticky flag for any grant whose unwrapped address runs past the memory.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      oob_q <= 1'b0;
    end else if (w_grant && w_oob) begin
      oob_q <= 1'b1;
    end
  end

  // Activity FSM: tracks pending work and stall periods for busy reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|lane_wr_req) state_q <= ARB_ACTIVE;
        end
        ARB_ACTIVE: begin
          if (stall_i)                            state_q <= ARB_STALL;
          else if (!(|lane_wr_req) && !(|ack_q))  state_q <= ARB_IDLE;
        end
        ARB_STALL: begin
          if (!stall_i) state_q <= ARB_ACTIVE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign lane_wr_ack_p = ack_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_wr_addr_o = addr_q;
  assign mem_wr_data_o = data_q;
  assign wr_count_o    = cnt_q;
  assign addr_oob_o    = oob_q;
  assign busy_o        = (state_q != ARB_IDLE) | (|lane_wr_req);

endmodule : npu_act_wr_arbiter
`default_nettype wire

// File: tb/tb_npu_act_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npu_act_wr_arbiter
//  Description : Directed self-checking bench for npu_act_wr_arbiter
//                (32 lanes, 12-bit addresses, 3000-word memory).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_act_wr_arbiter;

  localparam int NL = 32;
  localparam int AW = 12;
  localparam int MW = 12;
  localparam int DW = 16;
  localparam int CW = 16;

  logic              clk;
  logic              rst;
  logic [NL-1:0]     lane_wr_req;
  logic [NL*AW-1:0]  lane_wr_addr;
  logic [NL*DW-1:0]  lane_wr_data;
  logic [NL-1:0]     lane_wr_ack_p;
  logic [MW-1:0]     base_addr_i;
  logic              stall_i;
  logic              test_mode_i;
  logic              cnt_clr_i;
  logic              mem_wr_en_o;
  logic [MW-1:0]     mem_wr_addr_o;
  logic [DW-1:0]     mem_wr_data_o;
  logic              busy_o;
  logic [CW-1:0]     wr_count_o;
  logic              addr_oob_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  npu_act_wr_arbiter #(
    .NUM_LANES   (NL),
    .LANE_ADDR_W (AW),
    .MEM_ADDR_W  (MW),
    .MEM_DEPTH   (3000),
    .DATA_W      (DW),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lane_wr_req   (lane_wr_req),
    .lane_wr_addr  (lane_wr_addr),
    .lane_wr_data  (lane_wr_data),
    .lane_wr_ack_p (lane_wr_ack_p),
    .base_addr_i   (base_addr_i),
    .stall_i       (stall_i),
    .test_mode_i   (test_mode_i),
    .cnt_clr_i     (cnt_clr_i),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_addr_o (mem_wr_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .busy_o        (busy_o),
    .wr_count_o    (wr_count_o),
    .addr_oob_o    (addr_oob_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    lane_wr_addr[i*AW +: AW] = a;
    lane_wr_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst          = 1'b1;
    lane_wr_req  = '0;
    lane_wr_addr = '0;
    lane_wr_data = '0;
    base_addr_i  = '0;
    stall_i      = 1'b0;
    test_mode_i  = 1'b0;
    cnt_clr_i    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ack",   64'(lane_wr_ack_p), 64'h0);
    chk("rst_wren",  64'(mem_wr_en_o),   64'h0);
    chk("rst_addr",  64'(mem_wr_addr_o), 64'h0);
    chk("rst_data",  64'(mem_wr_data_o), 64'h0);
    chk("rst_cnt",   64'(wr_count_o),    64'h0);
    chk("rst_oob",   64'(addr_oob_o),    64'h0);
    chk("rst_busy",  64'(busy_o),        64'h0);

    // 1: single lane 5 with base offset
    base_addr_i = 12'h100;
    set_lane(5, 12'h010, 16'hBEEF);
    lane_wr_req[5] = 1'b1;
    tick();
    chk("t1_ack",  64'(lane_wr_ack_p), 64'h20);
    chk("t1_wren", 64'(mem_wr_en_o),   64'h1);
    chk("t1_addr", 64'(mem_wr_addr_o), 64'h110);
    chk("t1_data", 64'(mem_wr_data_o), 64'hBEEF);
    chk("t1_cnt",  64'(wr_count_o),    64'h1);
    lane_wr_req = '0;
    tick();
    chk("t1_ack_low",  64'(lane_wr_ack_p), 64'h0);
    chk("t1_wren_low", 64'(mem_wr_en_o),   64'h0);
    chk("t1_addr_hold", 64'(mem_wr_addr_o), 64'h110);

    // 2: all lanes requesting after reset; strict 0..31 order then back to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base_addr_i = '0;
    for (int i = 0; i < NL; i++) set_lane(i, AW'(i), DW'(16'h1000 + i));
    lane_wr_req = '1;
    for (int s = 0; s <= NL; s++) begin
      tick();
      chk($sformatf("t2_ack_step%0d", s),  64'(lane_wr_ack_p), 64'(1) << (s % NL));
      chk($sformatf("t2_addr_step%0d", s), 64'(mem_wr_addr_o), 64'(s % NL));
    end
    lane_wr_req = '0;
    tick();
    chk("t2_cnt", 64'(wr_count_o), 64'd33);

    // 3: lanes 3 and 7 alternate; a 4-cycle stall freezes everything
    lane_wr_req[3] = 1'b1;
    lane_wr_req[7] = 1'b1;
    tick();
    chk("t3_ack_a", 64'(lane_wr_ack_p), 64'h8);
    tick();
    chk("t3_ack_b", 64'(lane_wr_ack_p), 64'h80);
    stall_i = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("t3_stall_ack%0d", s),  64'(lane_wr_ack_p), 64'h0);
      chk($sformatf("t3_stall_busy%0d", s), 64'(busy_o),        64'h1);
    end
    stall_i = 1'b0;
    tick();
    chk("t3_resume_3", 64'(lane_wr_ack_p), 64'h8);
    tick();
    chk("t3_resume_7", 64'(lane_wr_ack_p), 64'h80);
    lane_wr_req = '0;
    tick();
    chk("t3_cnt", 64'(wr_count_o), 64'd37);

    // 4: address wrap, out-of-range flag, depth boundary, clear priority
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("t4_clr_cnt", 64'(wr_count_o), 64'h0);
    base_addr_i = 12'hF00;
    set_lane(2, 12'h200, 16'h1234);
    lane_wr_req[2] = 1'b1;
    tick();
    chk("t4_wrap_addr", 64'(mem_wr_addr_o), 64'h100);
    chk("t4_wrap_data", 64'(mem_wr_data_o), 64'h1234);
    chk("t4_wrap_wren", 64'(mem_wr_en_o),   64'h1);
    chk("t4_oob_set",   64'(addr_oob_o),    64'h1);
    lane_wr_req = '0;
    tick();
    chk("t4_oob_sticky", 64'(addr_oob_o), 64'h1);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("t4_oob_clr", 64'(addr_oob_o), 64'h0);
    chk("t4_cnt_clr", 64'(wr_count_o), 64'h0);
    base_addr_i = '0;
    set_lane(4, 12'hBB7, 16'h0004);
    lane_wr_req[4] = 1'b1;
    tick();
    chk("t4_depth_m1_addr", 64'(mem_wr_addr_o), 64'hBB7);
    chk("t4_depth_m1_oob",  64'(addr_oob_o),    64'h0);
    lane_wr_req = '0;
    tick();
    set_lane(4, 12'hBB8, 16'h0005);
    lane_wr_req[4] = 1'b1;
    tick();
    chk("t4_depth_oob", 64'(addr_oob_o), 64'h1);
    chk("t4_depth_cnt", 64'(wr_count_o), 64'h2);
    lane_wr_req = '0;
    tick();
    set_lane(4, 12'h001, 16'h0006);
    lane_wr_req[4] = 1'b1;
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    lane_wr_req = '0;
    chk("t4_clrwin_ack", 64'(lane_wr_ack_p), 64'h10);
    chk("t4_clrwin_cnt", 64'(wr_count_o),    64'h0);
    chk("t4_clrwin_oob", 64'(addr_oob_o),    64'h0);
    tick();

    // 5: test mode suppresses writes but still acks and counts
    test_mode_i = 1'b1;
    lane_wr_req[0] = 1'b1;
    lane_wr_req[1] = 1'b1;
    tick();
    chk("t5_ack0",  64'(lane_wr_ack_p), 64'h1);
    chk("t5_wren0", 64'(mem_wr_en_o),   64'h0);
    tick();
    chk("t5_ack1",  64'(lane_wr_ack_p), 64'h2);
    chk("t5_wren1", 64'(mem_wr_en_o),   64'h0);
    lane_wr_req = '0;
    tick();
    chk("t5_cnt", 64'(wr_count_o), 64'h2);
    test_mode_i = 1'b0;

    // 6: reset on the grant edge drops the write; re-request acks next clock
    lane_wr_req[2] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_ack",  64'(lane_wr_ack_p), 64'h0);
    chk("t6_wren", 64'(mem_wr_en_o),   64'h0);
    chk("t6_addr", 64'(mem_wr_addr_o), 64'h0);
    chk("t6_data", 64'(mem_wr_data_o), 64'h0);
    chk("t6_cnt",  64'(wr_count_o),    64'h0);
    chk("t6_oob",  64'(addr_oob_o),    64'h0);
    tick();
    chk("t6_reack",   64'(lane_wr_ack_p), 64'h4);
    chk("t6_rewren",  64'(mem_wr_en_o),   64'h1);
    chk("t6_readdr",  64'(mem_wr_addr_o), 64'h200);
    lane_wr_req = '0;
    tick();
    tick();
    chk("t6_idle_busy", 64'(busy_o),        64'h0);
    chk("t6_idle_ack",  64'(lane_wr_ack_p), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_npu_act_wr_arbiter
`default_nettype wire
